// File: rtl/huffman_tree_builder.sv
// -----------------------------------------------------------------------------
// huffman_tree_builder
//
// Builds the 2-D lookup table walked by the bit-serial Huffman decoder. It
// takes one code length per symbol, derives the canonical (RFC1951) codes, and
// writes the resulting binary tree into the shared table RAM. It owns the RAM
// ports while obusy is high.
//
// Table format, one word per {node,bit} address:
//   word <  NUMCODES : leaf, the decoded symbol
//   word >= NUMCODES : pointer to child node (word - NUMCODES)
//   word == all-ones : unfilled slot
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous reset, active high
//   istart  in   start a new table; aborts any build in progress
//   ien     in   ilen valid, taken only while oready is high
//   ilen    in   code length of the next symbol (0 = symbol unused)
//   oready  out  accepting code lengths
//   obusy   out  high from istart until odone
//   odone   out  one-cycle pulse, table complete (or failed)
//   oerr    out  over-subscribed / invalid tree, valid with odone, held until istart
//   wen     out  table write strobe
//   waddr   out  table write address {node,bit}
//   wdata   out  table write data
//   raddr   out  table read address; RAM returns rdata one cycle later
//   rdata   in   table read data
// -----------------------------------------------------------------------------
module huffman_tree_builder #(
    parameter int NUMCODES = 288,
    parameter int OUTWIDTH = 10,
    parameter int MAXLEN   = 15,
    localparam int AW      = $clog2(2 * NUMCODES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                istart,
    input  logic                ien,
    input  logic [3:0]          ilen,
    output logic                oready,
    output logic                obusy,
    output logic                odone,
    output logic                oerr,
    output logic                wen,
    output logic [AW-1:0]       waddr,
    output logic [OUTWIDTH-1:0] wdata,
    output logic [AW-1:0]       raddr,
    input  logic [OUTWIDTH-1:0] rdata
);

    localparam int NW = AW - 1;                    // node index width
    localparam int SW = $clog2(NUMCODES + 1);      // symbol counter, counts up to NUMCODES
    localparam int CW = MAXLEN + 1;                // canonical code arithmetic width
    localparam logic [OUTWIDTH-1:0] UNFILLED = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_NEXTCODE,
        S_INSERT,
        S_DONE
    } state_t;

    // INSERT sub-phases: pick symbol, wait for registered read, examine rdata.
    typedef enum logic [1:0] {
        P_SYM,
        P_RD,
        P_EX
    } phase_t;

    state_t              state_q;
    phase_t              phase_q;
    logic [SW-1:0]       sym_q;
    logic [AW-1:0]       clr_q;
    logic [3:0]          b_q;
    logic [CW-1:0]       code_q;
    logic [3:0]          bit_q;
    logic [NW-1:0]       node_q;
    logic [NW-1:0]       nf_q;
    logic [SW-1:0]       bl_count_q [1:MAXLEN];
    logic [CW-1:0]       next_code_q [1:MAXLEN];
    logic [3:0]          len_mem [NUMCODES];

    logic                oready_q;
    logic                obusy_q;
    logic                odone_q;
    logic                oerr_q;
    logic                wen_q;
    logic [AW-1:0]       waddr_q;
    logic [OUTWIDTH-1:0] wdata_q;
    logic [AW-1:0]       raddr_q;

    assign oready = oready_q;
    assign obusy  = obusy_q;
    assign odone  = odone_q;
    assign oerr   = oerr_q;
    assign wen    = wen_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign raddr  = raddr_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [NW-1:0]       sym_idx;
    logic [3:0]          cur_len;
    logic [3:0]          len_idx;
    logic [CW-1:0]       cur_code;
    logic [3:0]          nc_prev;
    logic [CW-1:0]       next_code_d;
    logic [3:0]          next_bit;
    logic [NW-1:0]       alloc_node_d;
    logic [NW-1:0]       child_node_d;
    logic                sym_end;
    logic                rd_unfilled;
    logic                rd_is_ptr;
    logic                len_we;
    logic                nc_init_we;
    logic                nc_inc_we;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        sym_idx      = sym_q[NW-1:0];
        sym_end      = (sym_q == SW'(NUMCODES));
        cur_len      = sym_end ? 4'd0 : len_mem[sym_idx];
        len_idx      = (cur_len == 4'd0) ? 4'd1 : cur_len;
        cur_code     = next_code_q[len_idx];
        nc_prev      = (b_q <= 4'd1) ? 4'd1 : b_q - 4'd1;
        next_code_d  = '0;
        if (b_q > 4'd1) begin
            next_code_d = (next_code_q[nc_prev] + CW'(bl_count_q[nc_prev])) << 1;
        end
        next_bit     = bit_q - 4'd1;
        alloc_node_d = nf_q + NW'(1);
        child_node_d = NW'(rdata - OUTWIDTH'(NUMCODES));
        rd_unfilled  = (rdata == UNFILLED);
        rd_is_ptr    = (rdata >= OUTWIDTH'(NUMCODES));

        len_we     = !istart && (state_q == S_LOAD) && ien;
        nc_init_we = !istart && (state_q == S_NEXTCODE);
        nc_inc_we  = !istart && (state_q == S_INSERT) && (phase_q == P_SYM) &&
                     !sym_end && (cur_len != 4'd0);
    end

    // -------------------------------------------------------------------------
    // Storage arrays: code lengths and next_code registers
    // -------------------------------------------------------------------------
    // NOTE: these arrays are storage, not control state, so they take no reset;
    // every entry is written before it is read in each build.
    always_ff @(posedge clk) begin
        if (len_we) begin
            len_mem[sym_idx] <= ilen;
        end
    end

    always_ff @(posedge clk) begin
        if (nc_init_we) begin
            next_code_q[b_q] <= next_code_d;
        end else if (nc_inc_we) begin
            next_code_q[len_idx] <= next_code_q[len_idx] + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Main FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= P_SYM;
            sym_q    <= '0;
            clr_q    <= '0;
            b_q      <= '0;
            code_q   <= '0;
            bit_q    <= '0;
            node_q   <= '0;
            nf_q     <= '0;
            oready_q <= 1'b0;
            obusy_q  <= 1'b0;
            odone_q  <= 1'b0;
            oerr_q   <= 1'b0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            raddr_q  <= '0;
            for (int i = 1; i <= MAXLEN; i++) begin
                bl_count_q[i] <= '0;
            end
        end else begin
            odone_q <= 1'b0;
            wen_q   <= 1'b0;

            if (istart) begin
                state_q  <= S_LOAD;
                sym_q    <= '0;
                oerr_q   <= 1'b0;
                oready_q <= 1'b1;
                obusy_q  <= 1'b1;
                for (int i = 1; i <= MAXLEN; i++) begin
                    bl_count_q[i] <= '0;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                    end

                    S_LOAD: begin
                        if (ien) begin
                            if (ilen != 4'd0) begin
                                bl_count_q[ilen] <= bl_count_q[ilen] + SW'(1);
                            end
                            if (sym_q == SW'(NUMCODES - 1)) begin
                                state_q  <= S_CLEAR;
                                oready_q <= 1'b0;
                                clr_q    <= '0;
                            end else begin
                                sym_q <= sym_q + SW'(1);
                            end
                        end
                    end

                    S_CLEAR: begin
                        wen_q   <= 1'b1;
                        waddr_q <= clr_q;
                        wdata_q <= UNFILLED;
                        if (clr_q == AW'(2 * NUMCODES - 1)) begin
                            state_q <= S_NEXTCODE;
                            b_q     <= 4'd1;
                        end else begin
                            clr_q <= clr_q + AW'(1);
                        end
                    end

                    // One next_code entry per cycle; each uses the entry
                    // written on the previous cycle.
                    S_NEXTCODE: begin
                        if (b_q == 4'(MAXLEN)) begin
                            state_q <= S_INSERT;
                            phase_q <= P_SYM;
                            sym_q   <= '0;
                            nf_q    <= '0;
                        end else begin
                            b_q <= b_q + 4'd1;
                        end
                    end

                    S_INSERT: begin
                        unique case (phase_q)
                            P_SYM: begin
                                if (sym_end) begin
                                    state_q <= S_DONE;
                                    odone_q <= 1'b1;
                                    obusy_q <= 1'b0;
                                end else if (cur_len == 4'd0) begin
                                    sym_q <= sym_q + SW'(1);
                                end else begin
                                    code_q  <= cur_code;
                                    bit_q   <= cur_len - 4'd1;
                                    node_q  <= '0;
                                    raddr_q <= {NW'(0), cur_code[cur_len - 4'd1]};
                                    phase_q <= P_RD;
                                end
                            end

                            P_RD: begin
                                phase_q <= P_EX;
                            end

                            P_EX: begin
                                if (bit_q == 4'd0) begin
                                    if (rd_unfilled) begin
                                        wen_q   <= 1'b1;
                                        waddr_q <= raddr_q;
                                        wdata_q <= OUTWIDTH'(sym_q);
                                        sym_q   <= sym_q + SW'(1);
                                        phase_q <= P_SYM;
                                    end else begin
                                        oerr_q  <= 1'b1;
                                        state_q <= S_DONE;
                                        odone_q <= 1'b1;
                                        obusy_q <= 1'b0;
                                    end
                                end else if (rd_unfilled) begin
                                    // Interior slot is empty: allocate a new
                                    // node unless all N-1 internal nodes exist.
                                    if (nf_q == NW'(NUMCODES - 2)) begin
                                        oerr_q  <= 1'b1;
                                        state_q <= S_DONE;
                                        odone_q <= 1'b1;
                                        obusy_q <= 1'b0;
                                    end else begin
                                        nf_q    <= alloc_node_d;
                                        wen_q   <= 1'b1;
                                        waddr_q <= raddr_q;
                                        wdata_q <= OUTWIDTH'(NUMCODES) + OUTWIDTH'(alloc_node_d);
                                        node_q  <= alloc_node_d;
                                        raddr_q <= {alloc_node_d, code_q[next_bit]};
                                        bit_q   <= next_bit;
                                        phase_q <= P_RD;
                                    end
                                end else if (rd_is_ptr) begin
                                    node_q  <= child_node_d;
                                    raddr_q <= {child_node_d, code_q[next_bit]};
                                    bit_q   <= next_bit;
                                    phase_q <= P_RD;
                                end else begin
                                    // Path runs into an existing leaf.
                                    oerr_q  <= 1'b1;
                                    state_q <= S_DONE;
                                    odone_q <= 1'b1;
                                    obusy_q <= 1'b0;
                                end
                            end

                            default: begin
                                phase_q <= P_SYM;
                            end
                        endcase
                    end

                    S_DONE: begin
                        state_q <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_huffman_tree_builder.sv
// -----------------------------------------------------------------------------
// tb_huffman_tree_builder
//
// Two builders share one stimulus stream: a small alphabet (8 symbols) and the
// full deflate literal/length alphabet (288 symbols); sel chooses which one
// sees istart/ien. A reference model derives canonical codes and the expected
// write sequence and table from the code lengths; a compare process checks
// every table write and, at odone, the error flag and the whole table.
// -----------------------------------------------------------------------------
module tb_huffman_tree_builder;

    localparam int UNF = 1023;

    logic clk = 1'b0;
    logic rst;
    logic istart;
    logic ien;
    logic [3:0] ilen;
    int   sel;

    always #5 clk = ~clk;

    // Small alphabet instance
    logic       istart_a, ien_a;
    logic       ready_a, busy_a, done_a, err_a, wen_a;
    logic [3:0] waddr_a, raddr_a;
    logic [9:0] wdata_a, rdata_a;
    logic [9:0] ram_a [16];

    // Full alphabet instance
    logic       istart_b, ien_b;
    logic       ready_b, busy_b, done_b, err_b, wen_b;
    logic [9:0] waddr_b, raddr_b;
    logic [9:0] wdata_b, rdata_b;
    logic [9:0] ram_b [576];

    assign istart_a = istart && (sel == 0);
    assign ien_a    = ien && (sel == 0);
    assign istart_b = istart && (sel == 1);
    assign ien_b    = ien && (sel == 1);

    huffman_tree_builder #(.NUMCODES(8), .OUTWIDTH(10), .MAXLEN(15)) dut_a (
        .clk(clk), .rst(rst), .istart(istart_a), .ien(ien_a), .ilen(ilen),
        .oready(ready_a), .obusy(busy_a), .odone(done_a), .oerr(err_a),
        .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .raddr(raddr_a), .rdata(rdata_a)
    );

    huffman_tree_builder #(.NUMCODES(288), .OUTWIDTH(10), .MAXLEN(15)) dut_b (
        .clk(clk), .rst(rst), .istart(istart_b), .ien(ien_b), .ilen(ilen),
        .oready(ready_b), .obusy(busy_b), .odone(done_b), .oerr(err_b),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .raddr(raddr_b), .rdata(rdata_b)
    );

    // Table RAMs: synchronous write, registered read (old data on collision)
    always @(posedge clk) begin
        if (wen_a) ram_a[waddr_a] <= wdata_a;
        rdata_a <= ram_a[raddr_a];
    end

    always @(posedge clk) begin
        if (wen_b) ram_b[waddr_b] <= wdata_b;
        rdata_b <= ram_b[raddr_b];
    end

    // Active-instance view
    logic ready_m, busy_m, done_m, err_m, wen_m;
    int   waddr_m, wdata_m;

    always_comb begin
        ready_m = ready_a;
        busy_m  = busy_a;
        done_m  = done_a;
        err_m   = err_a;
        wen_m   = wen_a;
        waddr_m = int'(waddr_a);
        wdata_m = int'(wdata_a);
        if (sel == 1) begin
            ready_m = ready_b;
            busy_m  = busy_b;
            done_m  = done_b;
            err_m   = err_b;
            wen_m   = wen_b;
            waddr_m = int'(waddr_b);
            wdata_m = int'(wdata_b);
        end
    end

    // -------------------------------------------------------------------------
    // Bookkeeping and check
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rd(input int a);
        if (sel == 0) return int'(ram_a[a[3:0]]);
        return int'(ram_b[a[9:0]]);
    endfunction

    // Walk the active table with nbits of code (MSB first); returns the leaf
    // symbol, or -1 if the walk leaves the tree.
    function automatic int walk(input int n, input int nbits, input logic [15:0] code);
        int node;
        int w;
        node = 0;
        for (int k = nbits - 1; k >= 0; k--) begin
            w = rd(node * 2 + int'(code[k]));
            if (k == 0) return w;
            if (w == UNF || w < n) return -1;
            node = w - n;
        end
        return -1;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    int lens [288];
    int n_cur = 8;
    int exp_tab [576];
    int exp_wa [1200];
    int exp_wd [1200];
    int exp_nwr = 0;
    int exp_err = 0;

    task automatic model_build(input int n);
        int          blc [16];
        logic [15:0] nc  [16];
        logic [15:0] code;
        int          nf, node, a, len;
        n_cur   = n;
        exp_nwr = 0;
        exp_err = 0;
        nf      = 0;
        for (int i = 0; i < 16; i++) blc[i] = 0;
        for (int s = 0; s < n; s++) if (lens[s] != 0) blc[lens[s]]++;
        nc[0] = 16'd0;
        nc[1] = 16'd0;
        for (int b = 2; b < 16; b++) nc[b] = (nc[b-1] + 16'(blc[b-1])) << 1;
        for (int i = 0; i < 2 * n; i++) begin
            exp_tab[i]       = UNF;
            exp_wa[exp_nwr]  = i;
            exp_wd[exp_nwr]  = UNF;
            exp_nwr++;
        end
        for (int s = 0; s < n && exp_err == 0; s++) begin
            len = lens[s];
            if (len != 0) begin
                code    = nc[len];
                nc[len] = nc[len] + 16'd1;
                node    = 0;
                for (int b = len - 1; b >= 0 && exp_err == 0; b--) begin
                    a = node * 2 + int'(code[b]);
                    if (b == 0) begin
                        if (exp_tab[a] == UNF) begin
                            exp_tab[a] = s;
                            exp_wa[exp_nwr] = a;
                            exp_wd[exp_nwr] = s;
                            exp_nwr++;
                        end else begin
                            exp_err = 1;
                        end
                    end else if (exp_tab[a] == UNF) begin
                        if (nf + 1 > n - 2) begin
                            exp_err = 1;
                        end else begin
                            nf++;
                            exp_tab[a] = n + nf;
                            exp_wa[exp_nwr] = a;
                            exp_wd[exp_nwr] = n + nf;
                            exp_nwr++;
                            node = nf;
                        end
                    end else if (exp_tab[a] >= n) begin
                        node = exp_tab[a] - n;
                    end else begin
                        exp_err = 1;
                    end
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Compare process: every write, and the finished table at odone
    // -------------------------------------------------------------------------
    int wr_idx = 0;
    int done_cnt = 0;
    int wen_cnt = 0;

    always @(posedge clk) if (wen_m) wen_cnt++;

    always @(negedge clk) begin
        if (istart) begin
            wr_idx = 0;
        end else begin
            if (wen_m) begin
                if (wr_idx < exp_nwr) begin
                    check("write_addr", waddr_m, exp_wa[wr_idx]);
                    check("write_data", wdata_m, exp_wd[wr_idx]);
                end else begin
                    check("unexpected_write", wr_idx, exp_nwr - 1);
                end
                wr_idx++;
            end
            if (done_m) begin
                done_cnt++;
                check("oerr_at_done", int'(err_m), exp_err);
                check("write_count", wr_idx, exp_nwr);
                for (int a = 0; a < 2 * n_cur; a++) check("table_word", rd(a), exp_tab[a]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic do_start(input int n);
        @(posedge clk); #1;
        model_build(n);
        istart = 1'b1;
        @(posedge clk); #1;
        istart = 1'b0;
    endtask

    task automatic do_load(input int n);
        check("oready_in_load", int'(ready_m), 1);
        for (int s = 0; s < n; s++) begin
            ien  = 1'b1;
            ilen = 4'(lens[s]);
            @(posedge clk); #1;
        end
        ien  = 1'b0;
        ilen = 4'd0;
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int c = 0; c < 20000 && seen == 0; c++) begin
            @(negedge clk);
            if (done_m) seen = 1;
        end
        if (seen == 0) check("odone_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_case1();
        int l1 [8] = '{3, 3, 3, 3, 3, 2, 4, 4};
        for (int s = 0; s < 288; s++) lens[s] = 0;
        for (int s = 0; s < 8; s++) lens[s] = l1[s];
    endtask

    task automatic check_case1_walks(input int n, input string tag);
        check({tag, "_walk_A_010"},  walk(n, 3, 16'b010), 0);
        check({tag, "_walk_F_00"},   walk(n, 2, 16'b00), 5);
        check({tag, "_walk_G_1110"}, walk(n, 4, 16'b1110), 6);
        check({tag, "_walk_H_1111"}, walk(n, 4, 16'b1111), 7);
    endtask

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    int d0, w0, cnt;

    initial begin
        rst    = 1'b1;
        istart = 1'b0;
        ien    = 1'b0;
        ilen   = 4'd0;
        sel    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_a", int'({ready_a, busy_a, done_a, err_a, wen_a}), 0);
        check("reset_addr_a", int'({waddr_a, wdata_a, raddr_a}), 0);
        check("reset_ctrl_b", int'({ready_b, busy_b, done_b, err_b, wen_b}), 0);
        check("reset_addr_b", int'({waddr_b, wdata_b, raddr_b}), 0);
        #2 rst = 1'b0;

        // Case 1: small mixed-length tree
        sel = 0;
        set_case1();
        d0 = done_cnt;
        do_start(8);
        do_load(8);
        wait_done();
        check("c1_done_pulses", done_cnt - d0, 1);
        check("c1_oerr", int'(err_m), 0);
        check("c1_word0", rd(0), 9);
        check("c1_word3", rd(3), 10);
        check("c1_word4", rd(4), 0);
        check_case1_walks(8, "c1");

        // Case 2: fixed deflate literal/length tree
        sel = 1;
        for (int s = 0; s < 288; s++)
            lens[s] = (s < 144) ? 8 : (s < 256) ? 9 : (s < 280) ? 7 : 8;
        do_start(288);
        do_load(288);
        wait_done();
        check("c2_oerr", int'(err_m), 0);
        check("c2_walk_0000000", walk(288, 7, 16'b0000000), 256);
        check("c2_walk_00110000", walk(288, 8, 16'b00110000), 0);
        check("c2_walk_110010000", walk(288, 9, 16'b110010000), 144);
        check("c2_walk_11000111", walk(288, 8, 16'b11000111), 287);

        // Case 3: over-subscribed, all lengths 1
        sel = 0;
        for (int s = 0; s < 8; s++) lens[s] = 1;
        do_start(8);
        do_load(8);
        wait_done();
        check("c3_oerr", int'(err_m), 1);
        check("c3_word0", rd(0), 0);
        check("c3_word1", rd(1), 1);
        w0 = wen_cnt;
        repeat (5) @(posedge clk);
        #1 check("c3_no_wen_after_error", wen_cnt - w0, 0);
        check("c3_oerr_held", int'(err_m), 1);

        // Case 4: all lengths zero
        for (int s = 0; s < 8; s++) lens[s] = 0;
        do_start(8);
        do_load(8);
        wait_done();
        check("c4_oerr", int'(err_m), 0);
        cnt = 0;
        for (int a = 0; a < 16; a++) if (rd(a) == UNF) cnt++;
        check("c4_unfilled_words", cnt, 16);

        // Case 5: abort the fixed-tree build mid-INSERT, reload case 1 lengths
        sel = 1;
        for (int s = 0; s < 288; s++)
            lens[s] = (s < 144) ? 8 : (s < 256) ? 9 : (s < 280) ? 7 : 8;
        do_start(288);
        do_load(288);
        repeat (700) @(posedge clk);
        #1 check("c5_busy_before_abort", int'(busy_m), 1);
        set_case1();
        d0 = done_cnt;
        do_start(288);
        check("c5_wen_after_istart", int'(wen_m), 0);
        check("c5_oready_after_istart", int'(ready_m), 1);
        do_load(288);
        wait_done();
        check("c5_done_pulses", done_cnt - d0, 1);
        check("c5_word0", rd(0), 289);
        check_case1_walks(288, "c5");

        // Case 6: asynchronous reset in the middle of CLEAR
        sel = 0;
        set_case1();
        do_start(8);
        do_load(8);
        repeat (4) @(posedge clk);
        #1 check("c6_wen_in_clear", int'(wen_a), 1);
        #2 rst = 1'b1;
        #1 check("c6_rst_ctrl", int'({ready_a, busy_a, done_a, err_a, wen_a}), 0);
        check("c6_rst_addr", int'({waddr_a, wdata_a, raddr_a}), 0);
        #2 rst = 1'b0;
        w0 = wen_cnt;
        repeat (10) @(posedge clk);
        #1 check("c6_no_wen_before_istart", wen_cnt - w0, 0);
        check("c6_idle_after_reset", int'({ready_a, busy_a}), 0);
        d0 = done_cnt;
        do_start(8);
        do_load(8);
        wait_done();
        check("c6_done_pulses", done_cnt - d0, 1);
        check("c6_word0", rd(0), 9);
        check_case1_walks(8, "c6");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
